uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving sample_trigger pulses per bit period (even, >= 8).
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame (5..9).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is in this domain.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low (asserted at 0).
REQ-005 SHALL have port sample_trigger, input, 1, one-clk strobe at OVERSAMPLE x baud, from the pulse generator.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idle is high.
REQ-007 SHALL have port data, output, DATA_BITS, last good received word.
REQ-008 SHALL have port data_valid, output, 1, one-clk pulse when data is updated.
REQ-009 SHALL have port framing_error, output, 1, one-clk pulse on a bad stop bit.
REQ-010 SHALL have port parity_error, output, 1, one-clk pulse on a parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-012 SHALL advance state, sample counter and votes only on cycles where sample_trigger=1; all other cycles hold.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-014 IDLE: on a trigger with synced rx=0, SHALL go to START with sample count=0.
REQ-015 Each bit spans OVERSAMPLE triggers, count 0..OVERSAMPLE-1; the bit value SHALL be the majority of samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-016 START: if the voted value is 1, SHALL return to IDLE at the vote trigger (glitch rejection) with no output pulse.
REQ-017 START/DATA/PARITY: SHALL move to the next state at the trigger where count=OVERSAMPLE-1 and reset count to 0.
REQ-018 DATA: SHALL shift bits in LSB first; after DATA_BITS bits SHALL go to PARITY (macro) or STOP.
REQ-019 STOP: at the vote trigger, SHALL return to IDLE immediately so the next start edge resyncs.
REQ-020 STOP vote 1: data SHALL load the shifted word and data_valid SHALL pulse for exactly one clk.
REQ-021 STOP vote 0: framing_error SHALL pulse for one clk, data SHALL be unchanged and data_valid SHALL stay 0.
REQ-022 data SHALL hold its value between pulses; there is no backpressure, and a new frame overwrites data.
REQ-023 Output latency SHALL be one clk after the stop-vote trigger edge (registered outputs).
REQ-024 If rx stays low through STOP (break condition), SHALL report framing_error once and then re-enter START only on a fresh trigger with rx=0 from IDLE.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE, count=0, shift register=0, data=0, data_valid=0, framing_error=0, parity_error=0, synchronizer=1.
REQ-026 Reset mid-frame SHALL abandon the frame with no pulse; the first frame after deassertion SHALL be received normally.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, SHALL expect one even-parity bit after the data bits and add the PARITY state and the parity_error port.
REQ-028 With the macro, a parity mismatch with a good stop bit SHALL pulse parity_error together with data_valid, and data SHALL still load.
REQ-029 Without the macro, frames SHALL be 8N1-style (start, DATA_BITS, stop), with no PARITY state and no parity_error port.

Structure
REQ-030 Package uart_pkg SHALL hold the receiver state enum and the default OVERSAMPLE and DATA_BITS constants.
REQ-031 The two-flop synchronizer SHALL be the sub-module bit_synchronizer, with a reset value parameter.

Verification
REQ-032 Trigger every 4 clks, frame 0xA5 with a good stop -> exactly one data_valid with data=0xA5 and framing_error=0.
REQ-033 rx low for 4 triggers then high -> no pulses, state back in IDLE, and the next 0x3C frame is received correctly.
REQ-034 Frame 0x5A with stop bit 0 -> framing_error pulses once, data_valid=0, data keeps its prior value.
REQ-035 Single-trigger inversion at count 8 of data bit 3 of 0xFF -> data=0xFF (majority corrects).
REQ-036 rst pulsed low at data bit 4 of a frame -> all outputs 0 immediately, no pulse; the following 0x81 frame -> data=0x81.
REQ-037 With UART_RX_PARITY_EN, 0x03 sent with parity bit 1 -> data_valid and parity_error in the same clk, data=0x03.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared receiver state encoding, default frame parameters, voter.
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int C_OVERSAMPLE = 16;
  localparam int C_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// ============================================================================
// bit_synchronizer : two-flop synchronizer with a configurable reset value.
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// uart_receiver : oversampled UART receiver with 3-sample majority voting.
// Optional even parity bit when UART_RX_PARITY_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = C_OVERSAMPLE,
  parameter int DATA_BITS  = C_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_trigger,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int c_cnt_w = $clog2(OVERSAMPLE);
  localparam int c_idx_w = $clog2(DATA_BITS);

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [c_cnt_w-1:0] c_vote0    = c_cnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_vote1    = c_cnt_w'(OVERSAMPLE / 2);
  localparam logic [c_cnt_w-1:0] c_vote2    = c_cnt_w'(OVERSAMPLE / 2 + 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS - 1);

  logic                 w_rx;
  logic                 w_vote;
  logic                 w_vote_pt;
  logic                 w_cnt_last;
  logic [c_cnt_w-1:0]   w_cnt_next;

  rx_state_e            r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_bit_idx;
  logic                 r_s0;
  logic                 r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_break;
`ifdef UART_RX_PARITY_EN
  logic                 r_par;
  logic                 r_par_err;
`endif

  bit_synchronizer #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx)
  );

  assign w_vote     = maj3(r_s0, r_s1, w_rx);
  assign w_vote_pt  = (r_cnt == c_vote2);
  assign w_cnt_last = (r_cnt == c_cnt_last);
  assign w_cnt_next = w_cnt_last ? '0 : r_cnt + c_cnt_w'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_shift       <= '0;
      r_break       <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par         <= 1'b0;
      r_par_err     <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      if (sample_trigger) begin
        if (r_cnt == c_vote0) r_s0 <= w_rx;
        if (r_cnt == c_vote1) r_s1 <= w_rx;
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            // After a framing error the line must return high before re-arming,
            // so a held break reports only once.
            if (w_rx) begin
              r_break <= 1'b0;
            end else if (!r_break) begin
              r_state   <= ST_START;
              r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              r_par     <= 1'b0;
`endif
            end
          end
          ST_START: begin
            r_cnt <= w_cnt_next;
            if (w_vote_pt && w_vote) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (w_cnt_last) begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_cnt <= w_cnt_next;
            if (w_vote_pt) begin
              r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
              r_par   <= r_par ^ w_vote;
`endif
            end
            if (w_cnt_last) begin
              if (r_bit_idx == c_idx_last) begin
                r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                r_state   <= ST_PARITY;
`else
                r_state   <= ST_STOP;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + c_idx_w'(1);
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            r_cnt <= w_cnt_next;
            if (w_vote_pt) r_par_err <= r_par ^ w_vote;
            if (w_cnt_last) r_state <= ST_STOP;
          end
`endif
          ST_STOP: begin
            r_cnt <= w_cnt_next;
            if (w_vote_pt) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              if (w_vote) begin
                data         <= r_shift;
                data_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_error <= r_par_err;
`endif
              end else begin
                framing_error <= 1'b1;
                r_break       <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
